// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/flow controller.
package pipeline_pkg;

   localparam int unsigned RegAddrW = 5;
   localparam logic [31:0] NopInstr = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_TRAP   = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StMdWait    = 2'd1,
      StTrapDrain = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: EX load whose destination feeds an ID source.
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic                ex_is_load_i,
   input  logic [RegAddrW-1:0] ex_rd_i,
   input  logic [RegAddrW-1:0] id_rs1_i,
   input  logic [RegAddrW-1:0] id_rs2_i,
   input  logic                id_uses_rs1_i,
   input  logic                id_uses_rs2_i,
   output logic                hazard_o
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign hazard_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/next-PC controller with mul/div wait and trap drain states.
module pipeline_ctrl
   import pipeline_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [RegAddrW-1:0] id_rs1_i,
   input  logic [RegAddrW-1:0] id_rs2_i,
   input  logic                id_uses_rs1_i,
   input  logic                id_uses_rs2_i,
   input  logic [RegAddrW-1:0] ex_rd_i,
   input  logic                ex_is_load_i,
   input  logic                ex_redirect_i,
   input  logic                ex_md_start_i,
   input  logic                md_done_i,
   input  logic                imem_ready_i,
   input  logic                dmem_req_i,
   input  logic                dmem_ready_i,
   input  logic                trap_req_i,
   output logic                pc_stall_o,
   output logic                if_id_stall_o,
   output logic                id_ex_stall_o,
   output logic                ex_mem_stall_o,
   output logic                if_id_flush_o,
   output logic                id_ex_flush_o,
   output logic                ex_mem_flush_o,
   output logic                mem_wb_flush_o,
   output pc_sel_e             pc_sel_o,
   output logic [31:0]         stall_cnt_o
);

   ctrl_state_e state_q, state_d;
   logic [31:0] stall_cnt_q;
   logic        load_use;
   logic        dmem_wait;
   logic        md_active;

   load_use_detect u_load_use_detect (
      .ex_is_load_i  (ex_is_load_i),
      .ex_rd_i       (ex_rd_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .hazard_o      (load_use)
   );

   assign dmem_wait = dmem_req_i && !dmem_ready_i;
   assign md_active = (state_q == StMdWait) || ex_md_start_i;

   always_comb begin
      state_d        = state_q;
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      id_ex_stall_o  = 1'b0;
      ex_mem_stall_o = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      mem_wb_flush_o = 1'b0;
      pc_sel_o       = PC_SEQ;

      if (rst) begin
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         mem_wb_flush_o = 1'b1;
      end else if (trap_req_i) begin
         pc_sel_o       = PC_TRAP;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         state_d        = StTrapDrain;
      end else if (state_q == StTrapDrain) begin
         // the fetch launched before the trap vector was taken is stale
         if_id_flush_o = 1'b1;
         state_d       = StRun;
      end else if (dmem_wait) begin
         pc_stall_o     = 1'b1;
         if_id_stall_o  = 1'b1;
         id_ex_stall_o  = 1'b1;
         ex_mem_stall_o = 1'b1;
         mem_wb_flush_o = 1'b1;
      end else if (md_active && !md_done_i) begin
         pc_stall_o     = 1'b1;
         if_id_stall_o  = 1'b1;
         id_ex_stall_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         state_d        = StMdWait;
      end else begin
         // also completes MD_WAIT when md_done_i arrives
         state_d = StRun;
         if (ex_redirect_i) begin
            pc_sel_o      = PC_BRANCH;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (!imem_ready_i) begin
            pc_stall_o    = 1'b1;
            if_id_flush_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StRun;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (if_id_stall_o) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected outputs queued per driven cycle, popped at sample.
module tb_pipeline_ctrl;
   import pipeline_pkg::*;

   // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, pc_sel}
   localparam logic [9:0] E_NONE  = 10'b0000_0000_00;
   localparam logic [9:0] E_LU    = 10'b1100_0100_00;
   localparam logic [9:0] E_MD    = 10'b1110_0010_00;
   localparam logic [9:0] E_RED   = 10'b0000_1100_01;
   localparam logic [9:0] E_TRAP  = 10'b0000_1110_10;
   localparam logic [9:0] E_DRAIN = 10'b0000_1000_00;
   localparam logic [9:0] E_DMEM  = 10'b1111_0001_00;
   localparam logic [9:0] E_IMEM  = 10'b1000_1000_00;
   localparam logic [9:0] E_RST   = 10'b0000_1111_00;

   typedef struct {
      logic       rst;
      logic       load;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       redirect;
      logic       md_start;
      logic       md_done;
      logic       imem_ready;
      logic       dmem_req;
      logic       dmem_ready;
      logic       trap;
      logic [9:0] exp;
   } step_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect, ex_md_start, md_done;
   logic        imem_ready, dmem_req, dmem_ready, trap_req;
   logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   pc_sel_e     pc_sel;
   logic [31:0] stall_cnt;

   logic [9:0]  sb[$];
   logic [9:0]  exp_v;
   logic [31:0] exp_cnt;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_uses_rs1_i  (id_uses_rs1),
      .id_uses_rs2_i  (id_uses_rs2),
      .ex_rd_i        (ex_rd),
      .ex_is_load_i   (ex_is_load),
      .ex_redirect_i  (ex_redirect),
      .ex_md_start_i  (ex_md_start),
      .md_done_i      (md_done),
      .imem_ready_i   (imem_ready),
      .dmem_req_i     (dmem_req),
      .dmem_ready_i   (dmem_ready),
      .trap_req_i     (trap_req),
      .pc_stall_o     (pc_stall),
      .if_id_stall_o  (if_id_stall),
      .id_ex_stall_o  (id_ex_stall),
      .ex_mem_stall_o (ex_mem_stall),
      .if_id_flush_o  (if_id_flush),
      .id_ex_flush_o  (id_ex_flush),
      .ex_mem_flush_o (ex_mem_flush),
      .mem_wb_flush_o (mem_wb_flush),
      .pc_sel_o       (pc_sel),
      .stall_cnt_o    (stall_cnt)
   );

   function automatic logic [9:0] obs();
      return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel};
   endfunction

   function automatic step_t idle();
      step_t s;
      s.rst = 1'b0;      s.load = 1'b0;       s.rd = 5'd0;        s.rs1 = 5'd0;
      s.rs2 = 5'd0;      s.u1 = 1'b0;         s.u2 = 1'b0;        s.redirect = 1'b0;
      s.md_start = 1'b0; s.md_done = 1'b0;    s.imem_ready = 1'b1; s.dmem_req = 1'b0;
      s.dmem_ready = 1'b1; s.trap = 1'b0;     s.exp = E_NONE;
      return s;
   endfunction

   function automatic step_t lu(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic [9:0] exp);
      step_t s;
      s = idle();
      s.load = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.exp = exp;
      return s;
   endfunction

   task automatic drive(input step_t s);
      rst = s.rst;             ex_is_load = s.load;      ex_rd = s.rd;
      id_rs1 = s.rs1;          id_rs2 = s.rs2;           id_uses_rs1 = s.u1;
      id_uses_rs2 = s.u2;      ex_redirect = s.redirect; ex_md_start = s.md_start;
      md_done = s.md_done;     imem_ready = s.imem_ready; dmem_req = s.dmem_req;
      dmem_ready = s.dmem_ready; trap_req = s.trap;
   endtask

   task automatic test_reset();
      step_t q[$];
      step_t s;
      s = idle(); s.rst = 1'b1; s.exp = E_RST; q.push_back(s);
      s = idle(); q.push_back(s);
      exp_cnt = '0;
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         if (q[i].rst) exp_cnt = '0;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL reset_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL reset_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_load_use();
      step_t q[$];
      q.push_back(lu(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, E_LU));   // rs2 match
      q.push_back(idle());                                   // bubble now in EX
      q.push_back(lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, E_NONE)); // x0 never hazards
      q.push_back(lu(5'd7, 5'd7, 5'd1, 1'b1, 1'b0, E_LU));   // rs1 match
      q.push_back(lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b0, E_NONE)); // rs2 matches but unused
      q.push_back(lu(5'd9, 5'd9, 5'd9, 1'b0, 1'b0, E_NONE)); // no sources used
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL lu_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL lu_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_md();
      step_t q[$];
      step_t s;
      s = idle(); s.md_start = 1'b1; s.exp = E_MD; q.push_back(s);
      for (int k = 0; k < 4; k++) begin
         s = idle(); s.exp = E_MD; q.push_back(s);
      end
      s = idle(); s.md_done = 1'b1; q.push_back(s);
      q.push_back(idle());                                   // back in RUN
      s = idle(); s.md_start = 1'b1; s.md_done = 1'b1; q.push_back(s);
      q.push_back(idle());                                   // no wait entered
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL md_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL md_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_redirect();
      step_t q[$];
      step_t s;
      s = lu(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, E_RED); s.redirect = 1'b1; q.push_back(s);
      s = idle(); s.redirect = 1'b1; s.exp = E_RED; q.push_back(s);
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL redir_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL redir_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_trap();
      step_t q[$];
      step_t s;
      s = idle(); s.md_start = 1'b1; s.exp = E_MD; q.push_back(s);
      s = idle(); s.exp = E_MD; q.push_back(s);
      s = idle(); s.trap = 1'b1; s.exp = E_TRAP; q.push_back(s);
      s = idle(); s.exp = E_DRAIN; q.push_back(s);
      q.push_back(idle());
      s = idle(); s.trap = 1'b1; s.exp = E_TRAP; q.push_back(s);
      s = idle(); s.trap = 1'b1; s.exp = E_TRAP; q.push_back(s);  // re-trap during drain
      s = idle(); s.exp = E_DRAIN; q.push_back(s);
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL trap_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL trap_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_dmem();
      step_t q[$];
      step_t s;
      for (int k = 0; k < 3; k++) begin
         s = idle(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0; s.redirect = 1'b1;
         s.exp = E_DMEM; q.push_back(s);
      end
      s = idle(); s.dmem_req = 1'b1; s.redirect = 1'b1; s.exp = E_RED; q.push_back(s);
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL dmem_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL dmem_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_imem();
      step_t q[$];
      step_t s;
      s = idle(); s.imem_ready = 1'b0; s.exp = E_IMEM; q.push_back(s);
      s = lu(5'd4, 5'd4, 5'd0, 1'b1, 1'b0, E_LU); s.imem_ready = 1'b0; q.push_back(s);
      s = idle(); s.imem_ready = 1'b0; s.redirect = 1'b1; s.exp = E_RED; q.push_back(s);
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL imem_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL imem_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_cnt_wrap();
      step_t q[$];
      // preload between edges; the last driven row is idle so nothing else updates it
      dut.stall_cnt_q = 32'hFFFF_FFFF;
      exp_cnt = 32'hFFFF_FFFF;
      q.push_back(lu(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, E_LU));
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL wrap_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL wrap_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   task automatic test_md_reset();
      step_t q[$];
      step_t s;
      s = idle(); s.md_start = 1'b1; s.exp = E_MD; q.push_back(s);
      s = idle(); s.exp = E_MD; q.push_back(s);
      s = idle(); s.rst = 1'b1; s.exp = E_RST; q.push_back(s);
      q.push_back(idle());                                   // RUN, not MD_WAIT
      q.push_back(lu(5'd6, 5'd6, 5'd0, 1'b1, 1'b0, E_LU));
      q.push_back(idle());
      foreach (q[i]) begin
         @(negedge clk); drive(q[i]); sb.push_back(q[i].exp); #2;
         exp_v = sb.pop_front();
         if (q[i].rst) exp_cnt = '0;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL mdrst_out[%0d] got=%b exp=%b", i, obs(), exp_v);
         end
         total++;
         if (stall_cnt !== exp_cnt) begin
            bad++; $display("FAIL mdrst_cnt[%0d] got=%h exp=%h", i, stall_cnt, exp_cnt);
         end
         if (exp_v[8]) exp_cnt++;
      end
   endtask

   initial begin
      drive(idle());
      rst = 1'b1;
      exp_cnt = '0;
      test_reset();
      test_load_use();
      test_md();
      test_redirect();
      test_trap();
      test_dmem();
      test_imem();
      test_cnt_wrap();
      test_md_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: id_rs1_i, id_rs2_i  in  5  ID source regs; id_uses_rs1_i, id_uses_rs2_i  in  1  source valid.
REQ-003 SHALL have ports: ex_rd_i  in  5  EX dest reg; ex_is_load_i  in  1  EX holds load; ex_redirect_i  in  1  EX branch/jump mispredict.
REQ-004 SHALL have ports: ex_md_start_i  in  1  EX issues mul/div; md_done_i  in  1  mul/div result valid.
REQ-005 SHALL have ports: imem_ready_i  in  1  fetch data valid; dmem_req_i, dmem_ready_i  in  1  MEM access pending/complete; trap_req_i  in  1  MEM-stage exception.
REQ-006 SHALL have ports: pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out  1  hold register; if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1  load NOP/bubble.
REQ-007 SHALL have ports: pc_sel_o  out  2  next-PC source (PC_SEQ/PC_BRANCH/PC_TRAP); stall_cnt_o  out  32  cycles with if_id_stall_o=1.

Function
REQ-008 FSM states RUN, MD_WAIT, TRAP_DRAIN; stall/flush/pc_sel outputs combinational from state and inputs.
REQ-009 Default (no event): all stalls 0, all flushes 0, pc_sel_o=PC_SEQ.
REQ-010 Priority, highest first: trap, dmem wait, MD_WAIT, redirect, load-use, imem wait.
REQ-011 Trap (trap_req_i=1, any state): pc_sel_o=PC_TRAP; flush IF/ID, ID/EX, EX/MEM; no stalls; next state TRAP_DRAIN (aborts MD_WAIT).
REQ-012 TRAP_DRAIN: exactly one cycle; if_id_flush_o=1 (discard in-flight fetch); next state RUN unless trap_req_i=1 again.
REQ-013 dmem wait (dmem_req_i=1, dmem_ready_i=0): stall PC, IF/ID, ID/EX, EX/MEM; mem_wb_flush_o=1; redirect/load-use/MD entry suppressed; state held.
REQ-014 MD entry: ex_md_start_i=1 in RUN -> MD_WAIT next cycle; entry cycle itself stalls PC, IF/ID, ID/EX and flushes EX/MEM unless md_done_i=1 same cycle.
REQ-015 MD_WAIT: stall PC, IF/ID, ID/EX; ex_mem_flush_o=1; on md_done_i=1 all stalls/flush deassert that same cycle, next state RUN.
REQ-016 Redirect (ex_redirect_i=1): pc_sel_o=PC_BRANCH; flush IF/ID and ID/EX; no stalls; overrides a simultaneous load-use hazard.
REQ-017 Load-use: ex_is_load_i=1, ex_rd_i!=0, and (id_uses_rs1_i and id_rs1_i==ex_rd_i or id_uses_rs2_i and id_rs2_i==ex_rd_i): stall PC, IF/ID; flush ID/EX; exactly one bubble per load.
REQ-018 ex_rd_i=0 SHALL never raise a load-use hazard.
REQ-019 imem wait (imem_ready_i=0, no higher event): pc_stall_o=1, if_id_flush_o=1; if a higher event also stalls IF/ID, stall wins, flush suppressed.
REQ-020 A stall and flush SHALL never both be 1 for the same register.
REQ-021 stall_cnt_o increments by 1 each cycle if_id_stall_o=1; wraps 2^32-1 -> 0.

Reset
REQ-022 rst=1 SHALL immediately (asynchronously) force state=RUN, stall_cnt_o=0.
REQ-023 While rst=1 all flush outputs=1, all stall outputs=0, pc_sel_o=PC_SEQ.
REQ-024 rst mid-MD_WAIT or mid-TRAP_DRAIN SHALL return to RUN; first post-reset cycle follows REQ-009..REQ-019.

Structure
REQ-025 pc_sel_e (PC_SEQ=0, PC_BRANCH=1, PC_TRAP=2), ctrl_state_e, and NOP constant 32'h0000_0013 SHALL live in shared pipeline_pkg.
REQ-026 Load-use comparison SHALL be sub-module load_use_detect (combinational, hazard_o); everything else in pipeline_ctrl.

Verification
REQ-027 ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 -> one cycle pc_stall_o=if_id_stall_o=id_ex_flush_o=1; stall_cnt_o +1.
REQ-028 ex_md_start_i pulse, md_done_i after 4 cycles -> 5 stalled cycles total, state RUN on cycle after md_done_i.
REQ-029 ex_redirect_i=1 with matching load-use -> pc_sel_o=PC_BRANCH, if_id_flush_o=id_ex_flush_o=1, if_id_stall_o=0.
REQ-030 trap_req_i=1 during MD_WAIT -> pc_sel_o=PC_TRAP, IF/ID/ID-EX/EX-MEM flushed, then one TRAP_DRAIN cycle, then RUN.
REQ-031 dmem_req_i=1, dmem_ready_i=0 for 3 cycles with ex_redirect_i=1 -> 3 freeze cycles, mem_wb_flush_o=1, pc_sel_o=PC_SEQ; redirect applied on 4th cycle.
REQ-032 stall_cnt_o preloaded at 32'hFFFF_FFFF, one stall -> 0; rst asserted mid-MD_WAIT -> stalls 0, flushes 1, counter 0.
